// File: rtl/hx8352_bus_writer.sv
// HX8352 8080-style parallel write-bus driver: one command/data word per start request.
// Latency: start sampled in IDLE at edge N -> CS/RS/DB driven after edge N; done after SETUP+WR_LOW+WR_HIGH+HOLD cycles.
// Backpressure: start is ignored while bus_busy=1 (no queueing); done cycle is IDLE so start there is accepted.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, is_cmd, data_in write request, RS select (1 = command, RS low), word to write
//   bus_busy, done        transfer in progress, one-cycle completion pulse
//   lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_db   panel bus (all registered)
module hx8352_bus_writer #(
    parameter int DATA_WIDTH     = 16,
    parameter int SETUP_CYCLES   = 1,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2,
    parameter int HOLD_CYCLES    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_cmd,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  bus_busy,
    output logic                  done,
    output logic                  lcd_cs_n,
    output logic                  lcd_rs,
    output logic                  lcd_wr_n,
    output logic                  lcd_rd_n,
    output logic [DATA_WIDTH-1:0] lcd_db
);

    // Phase counter load values (length - 1); a zero length behaves as one cycle.
    localparam logic [7:0] SETUP_LD   = (SETUP_CYCLES   <= 1) ? 8'd0 : 8'(SETUP_CYCLES   - 1);
    localparam logic [7:0] WR_LOW_LD  = (WR_LOW_CYCLES  <= 1) ? 8'd0 : 8'(WR_LOW_CYCLES  - 1);
    localparam logic [7:0] WR_HIGH_LD = (WR_HIGH_CYCLES <= 1) ? 8'd0 : 8'(WR_HIGH_CYCLES - 1);
    localparam logic [7:0] HOLD_LD    = (HOLD_CYCLES    <= 1) ? 8'd0 : 8'(HOLD_CYCLES    - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_WR_LOW  = 3'd2,
        S_WR_HIGH = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cs_n_q, cs_n_d;
    logic                  rs_q, rs_d;
    logic                  wr_n_q, wr_n_d;
    logic                  rd_n_q, rd_n_d;
    logic [DATA_WIDTH-1:0] db_q, db_d;

    // Outputs are computed for the state being entered, so every pin comes
    // straight from a flop and changes only at the phase boundaries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_n_d  = cs_n_q;
        rs_d    = rs_q;
        wr_n_d  = wr_n_q;
        rd_n_d  = 1'b1;
        db_d    = db_q;

        case (state_q)
            S_IDLE: begin
                // The RS/DB output flops double as the latch for the request.
                if (start) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    rs_d    = ~is_cmd;
                    db_d    = data_in;
                end
            end
            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_WR_LOW;
                    cnt_d   = WR_LOW_LD;
                    wr_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_WR_LOW: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_WR_HIGH;
                    cnt_d   = WR_HIGH_LD;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_WR_HIGH: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                busy_d  = 1'b0;
                cs_n_d  = 1'b1;
                wr_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            rs_q    <= 1'b1;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_n_q  <= cs_n_d;
            rs_q    <= rs_d;
            wr_n_q  <= wr_n_d;
            rd_n_q  <= rd_n_d;
            db_q    <= db_d;
        end
    end

    assign bus_busy = busy_q;
    assign done     = done_q;
    assign lcd_cs_n = cs_n_q;
    assign lcd_rs   = rs_q;
    assign lcd_wr_n = wr_n_q;
    assign lcd_rd_n = rd_n_q;
    assign lcd_db   = db_q;

endmodule

// File: doc/hx8352_bus_writer.md
Name: hx8352_bus_writer

Overview:
- Drives the HX8352 8080-style parallel write bus (CS/RS/WR/RD/DB) for the LCD controller FSM.
- Accepts one command or data word per start request and generates parameterised setup, WR-low, WR-high and hold phases.
- Reports progress to the FSM through bus_busy and a one-cycle done pulse.
- Its bus_busy output is the signal the controller FSM enabler gates the FSM clock on.

Parameters:
- DATA_WIDTH, 16, width of data_in and lcd_db.
- SETUP_CYCLES, 1, cycles CS/RS/DB are valid before WR falls.
- WR_LOW_CYCLES, 2, cycles lcd_wr_n is held low.
- WR_HIGH_CYCLES, 2, cycles lcd_wr_n is held high after the rising edge, with data still driven.
- HOLD_CYCLES, 1, cycles CS stays low after the WR-high phase.
- Each cycle parameter has a legal range of 1..255. A value of 0 is treated as 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  write request, sampled only in IDLE.
- is_cmd  in  1  1 = command/index write (RS low), 0 = data/parameter write (RS high). Sampled with start.
- data_in  in  DATA_WIDTH  word to write. Sampled with start.
- bus_busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer completes.
- lcd_cs_n  out  1  chip select, active low.
- lcd_rs  out  1  register select.
- lcd_wr_n  out  1  write strobe, active low. The panel latches on its rising edge.
- lcd_rd_n  out  1  read strobe. Held high; this block never reads.
- lcd_db  out  DATA_WIDTH  data bus.

Behaviour:
- All outputs are registered.
- Reset values (rst_n low, asynchronous): state IDLE, bus_busy 0, done 0, lcd_cs_n 1, lcd_rs 1, lcd_wr_n 1, lcd_rd_n 1, lcd_db 0, phase counter 0.
- State machine:
  - IDLE -> SETUP -> WR_LOW -> WR_HIGH -> HOLD -> IDLE.
  - An 8-bit phase counter is loaded with (phase length - 1) on entry to each phase and counts down. The state advances when the counter reads 0.
- IDLE:
  - lcd_cs_n 1, lcd_wr_n 1, bus_busy 0. lcd_rs and lcd_db keep their last values.
  - If start=1 at edge N: latch is_cmd and data_in; enter SETUP at edge N+1.
- SETUP: lcd_cs_n 0, lcd_rs = ~is_cmd latched, lcd_db = latched word, bus_busy 1. Lasts SETUP_CYCLES cycles.
- WR_LOW: lcd_wr_n 0; CS, RS and DB unchanged. Lasts WR_LOW_CYCLES cycles.
- WR_HIGH: lcd_wr_n 1; DB still driven. Lasts WR_HIGH_CYCLES cycles.
- HOLD: lcd_cs_n 0, lcd_wr_n 1. Lasts HOLD_CYCLES cycles.
- Transfer completion:
  - On leaving HOLD: lcd_cs_n 1, bus_busy 0, done 1 for exactly one cycle.
  - bus_busy is high for exactly SETUP+WR_LOW+WR_HIGH+HOLD cycles per transfer (6 with defaults).
  - Latency: start at edge N, bus_busy high from edge N+1, done high from edge N+1+total.
- Handshake rules:
  - start while bus_busy=1 is ignored. There is no queueing, and the latched word and RS are not modified.
  - start in the same cycle done=1 is accepted, because the block is already in IDLE. This gives back-to-back transfers with one idle cycle (CS high) between them.
  - start held high continuously produces repeated transfers, each separated by one IDLE cycle.
- Glitch rules:
  - lcd_wr_n toggles only at the SETUP->WR_LOW and WR_LOW->WR_HIGH boundaries.
  - lcd_cs_n never pulses high inside a transfer.
- Reset mid-transfer: all outputs return immediately to their reset values. In particular lcd_wr_n and lcd_cs_n go to 1 asynchronously, and no done pulse is issued. After reset release the block is in IDLE and accepts start on the first clock.
- lcd_rd_n is constant 1 after reset.

Test Plan:
- Command write, defaults: reset, then start=1, is_cmd=1, data_in=16'h0022 for one cycle.
  - Next edge: cs_n=0, rs=0, db=0x0022, bus_busy=1.
  - wr_n low for exactly 2 cycles, starting 1 cycle after CS falls.
  - bus_busy high 6 cycles; then done=1 for 1 cycle with cs_n=1.
- Data write: start with is_cmd=0, data_in=16'hA5C3 -> rs=1 and db=0xA5C3 held from SETUP through HOLD, with one wr_n rising edge while db is stable.
- Start while busy: start word 0x1111; pulse start again with 0x2222 two cycles later -> only 0x1111 appears on db, exactly one done pulse, one wr_n low pulse.
- Back-to-back: hold start=1 for two transfers (0x0001 then 0x0002) -> two done pulses, exactly one IDLE cycle with cs_n=1 between the transfers, second RS/DB correct.
- Reset mid-transfer: drop rst_n while wr_n=0 -> wr_n=1, cs_n=1, bus_busy=0 without a clock edge, and no done pulse.
  - After release, a start with 0x00FF completes normally.
- Non-default timing: SETUP=3, WR_LOW=4, WR_HIGH=1, HOLD=2 -> wr_n low 4 cycles starting 3 cycles after CS falls, bus_busy high 10 cycles.
  - Repeat with WR_LOW_CYCLES=0 -> wr_n low for 1 cycle.
